// File: rtl/register_write_arbiter_pkg.sv
// rtl/register_write_arbiter_pkg.sv - shared FSM encoding and helpers for the register write arbiter
package register_write_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Wide enough for MAX_BURST up to 15.
   localparam int BURST_CNT_W = 4;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/register_write_arbiter_rr_priority_picker.sv
// rtl/register_write_arbiter_rr_priority_picker.sv - combinational round-robin pick
// Returns the first requesting index found scanning upward from rr_ptr with wraparound.
module rr_priority_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_any
);

   int idx;

   always_comb begin
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      // Scan from the far end back so the candidate closest to rr_ptr wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (req_valid[idx]) begin
            grant_idx = IDX_W'(idx);
            grant_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/register_write_arbiter.sv
// rtl/register_write_arbiter.sv - round-robin arbiter granting write access to one shared register
// Supports locked bursts of up to MAX_BURST writes per grant.
module register_write_arbiter
   import register_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 4,
   parameter int OWNER_W    = $clog2(NUM_REQ)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_lock,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]         register,
   output logic [OWNER_W-1:0]            owner,
   output logic                          update
);

   state_t                 state_q, state_d;
   logic [OWNER_W-1:0]     owner_q, owner_d;
   logic [OWNER_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   logic [DATA_WIDTH-1:0]  register_q, register_d;
   logic                   update_q, update_d;

   logic [OWNER_W-1:0]     pick_idx;
   logic                   pick_any;
   logic                   accept;
   logic                   release_grant;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (OWNER_W)
   ) u_picker (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant_idx (pick_idx),
      .grant_any (pick_any)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
         register_q  <= '0;
         update_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         register_q  <= register_d;
         update_q    <= update_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      rr_ptr_d      = rr_ptr_q;
      burst_cnt_d   = burst_cnt_q;
      register_d    = register_q;
      accept        = 1'b0;
      release_grant = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               owner_d     = pick_idx;
               burst_cnt_d = '0;
               state_d     = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (req_valid[owner_q]) begin
               accept      = 1'b1;
               register_d  = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
               burst_cnt_d = burst_cnt_q + 1'b1;
               if (!req_lock[owner_q] || burst_cnt_q == BURST_CNT_W'(MAX_BURST - 1))
                  release_grant = 1'b1;
            end else if (!req_lock[owner_q]) begin
               release_grant = 1'b1;
            end
            if (release_grant) begin
               state_d  = ST_IDLE;
               rr_ptr_d = OWNER_W'(wrap_inc(int'(owner_q), NUM_REQ));
            end
         end
         default: state_d = ST_IDLE;
      endcase
      update_d = accept;
   end

   always_comb begin
      req_ready = '0;
      if (state_q == ST_BUSY)
         req_ready[owner_q] = 1'b1;
      register = register_q;
      owner    = owner_q;
      update   = update_q;
   end

endmodule
